// File: rtl/led_pkg.sv
// Mode encoding for the LED pattern generator; shared with the game-state control logic.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_SOLID = 2'd1,
        LED_BLINK = 2'd2,
        LED_CHASE = 2'd3
    } led_mode_e;

endpackage

// File: rtl/led_tick_div.sv
// Tick divider: pulses tick for one cycle every BLINK_DIV clocks; clr restarts the count.
module led_tick_div
    import led_pkg::*;
#(
    parameter int BLINK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] div_q;
    logic [CW-1:0] div_d;

    assign tick = (div_q == LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + CW'(1);
        if (clr) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/led_pattern.sv
// LED pattern generator: off / solid / blink (endless or counted burst) / chase.
// Optional PWM dimming of lit LEDs when LED_PWM_EN is defined.
module led_pattern
    import led_pkg::*;
#(
    parameter int N_LED     = 8,
    parameter int BLINK_DIV = 25000000,
    parameter int CNT_W     = 4
`ifdef LED_PWM_EN
    ,
    parameter int PWM_W     = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [CNT_W-1:0] cnt,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0] duty,
`endif
    output logic [N_LED-1:0] led,
    output logic             busy,
    output logic             done
);

    logic             tick;
    led_mode_e        mode_q,  mode_d;
    logic             phase_q, phase_d;
    logic [N_LED-1:0] chase_q, chase_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [N_LED-1:0] led_q,   led_d;
    logic [N_LED-1:0] pat;
    logic             gate;

    led_tick_div #(
        .BLINK_DIV (BLINK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (load),
        .tick (tick)
    );

    always_comb begin
        mode_d  = mode_q;
        phase_d = phase_q;
        chase_d = chase_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (load) begin
            mode_d  = led_mode_e'(mode);
            phase_d = 1'b1;
            chase_d = N_LED'(1);
            if (mode_d == LED_BLINK && cnt != '0) begin
                rem_d  = cnt;
                busy_d = 1'b1;
            end else begin
                rem_d  = '0;
                busy_d = 1'b0;
            end
        end else if (tick) begin
            case (mode_q)
                LED_BLINK: begin
                    phase_d = ~phase_q;
                    // A burst only counts down at the end of each lit phase.
                    if (phase_q && busy_q) begin
                        if (rem_q == CNT_W'(1)) begin
                            mode_d = LED_OFF;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            rem_d  = '0;
                        end else begin
                            rem_d = rem_q - CNT_W'(1);
                        end
                    end
                end
                LED_CHASE: chase_d = {chase_q[N_LED-2:0], chase_q[N_LED-1]};
                default: ;
            endcase
        end
    end

    always_comb begin
        case (mode_d)
            LED_OFF:   pat = '0;
            LED_SOLID: pat = '1;
            LED_BLINK: pat = phase_d ? '1 : '0;
            LED_CHASE: pat = chase_d;
        endcase
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_q;

    // Full duty bypasses the compare so all-ones means truly always on.
    assign gate = (duty == '1) || (pwm_q < duty);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + PWM_W'(1);
        end
    end
`else
    assign gate = 1'b1;
`endif

    generate
        for (genvar gi = 0; gi < N_LED; gi++) begin : g_gate
            assign led_d[gi] = pat[gi] & gate;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= LED_OFF;
            phase_q <= 1'b1;
            chase_q <= N_LED'(1);
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            phase_q <= phase_d;
            chase_q <= chase_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_pattern.sv
// Directed self-checking bench for led_pattern (N_LED=8, BLINK_DIV=4, CNT_W=4).
// Define LED_PWM_EN to also exercise the PWM dimming path.
module tb_led_pattern;
    import led_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       load;
    logic [3:0] cnt;
    logic [7:0] led;
    logic       busy;
    logic       done;
`ifdef LED_PWM_EN
    logic [1:0] duty;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_pattern #(
        .N_LED     (8),
        .BLINK_DIV (4),
        .CNT_W     (4)
`ifdef LED_PWM_EN
        ,
        .PWM_W     (2)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .load (load),
        .cnt  (cnt),
`ifdef LED_PWM_EN
        .duty (duty),
`endif
        .led  (led),
        .busy (busy),
        .done (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [1:0] m, input logic [3:0] c);
        mode = m;
        cnt  = c;
        load = 1'b1;
        step();
        load = 1'b0;
        $display("load mode=%0d cnt=%0d -> led=%h busy=%b done=%b", m, c, led, busy, done);
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; mode = 2'd0; cnt = 4'd0;
        step(); step();
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            checks++;
            if (led !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: got led=%h busy=%b done=%b expected led=00 busy=0 done=0",
                         j, led, busy, done);
            end
            step();
        end
        do_load(LED_BLINK, 4'd0);
        step(); step();
        rst = 1'b1;
        step();
        checks++;
        if (led !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_blink: got led=%h busy=%b expected led=00 busy=0", led, busy);
        end
        // reset must win over a simultaneous load
        mode = LED_SOLID; load = 1'b1;
        step();
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL reset_over_load: got led=%h expected 00", led);
        end
        load = 1'b0; rst = 1'b0;
        step();
        $display("reset done: led=%h busy=%b done=%b", led, busy, done);
    endtask

    task automatic test_solid_off();
        do_load(LED_SOLID, 4'd5);
        checks++;
        if (led !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL solid: got led=%h busy=%b expected led=FF busy=0", led, busy);
        end
        repeat (6) step();
        checks++;
        if (led !== 8'hFF) begin
            errors++;
            $display("FAIL solid_hold: got led=%h expected FF", led);
        end
        do_load(LED_OFF, 4'd0);
        checks++;
        if (led !== 8'h00) begin
            errors++;
            $display("FAIL off: got led=%h expected 00", led);
        end
    endtask

    task automatic test_blink_endless();
        logic [7:0] exp_led;
        do_load(LED_BLINK, 4'd0);
        for (int j = 0; j < 40; j++) begin
            exp_led = (((j / 4) % 2) == 0) ? 8'hFF : 8'h00;
            checks++;
            if (led !== exp_led || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL blink_endless cyc=%0d: got led=%h busy=%b done=%b expected led=%h busy=0 done=0",
                         j, led, busy, done, exp_led);
            end
            step();
        end
    endtask

    // Checks a counted burst of c on-phases starting right after its load edge.
    task automatic check_burst(input int c, input string name);
        logic [7:0] exp_led;
        logic       exp_busy;
        logic       exp_done;
        int         last;
        last = (2 * c - 1) * 4;
        for (int j = 0; j < last + 8; j++) begin
            exp_led  = (j < last && ((j / 4) % 2) == 0) ? 8'hFF : 8'h00;
            exp_busy = (j < last);
            exp_done = (j == last);
            checks++;
            if (led !== exp_led || busy !== exp_busy || done !== exp_done) begin
                errors++;
                $display("FAIL %s cyc=%0d: got led=%h busy=%b done=%b expected led=%h busy=%b done=%b",
                         name, j, led, busy, done, exp_led, exp_busy, exp_done);
            end
            step();
        end
    endtask

    task automatic test_blink_burst();
        do_load(LED_BLINK, 4'd3);
        check_burst(3, "burst3");
    endtask

    task automatic test_chase();
        logic [7:0] exp_led;
        logic [7:0] one;
        one = 8'h01;
        do_load(LED_CHASE, 4'd0);
        for (int j = 0; j < 40; j++) begin
            exp_led = one << ((j / 4) % 8);
            checks++;
            if (led !== exp_led || busy !== 1'b0) begin
                errors++;
                $display("FAIL chase cyc=%0d: got led=%h busy=%b expected led=%h busy=0",
                         j, led, busy, exp_led);
            end
            step();
        end
    endtask

    task automatic test_reload();
        do_load(LED_CHASE, 4'd0);
        repeat (9) step();
        checks++;
        if (led !== 8'h04) begin
            errors++;
            $display("FAIL chase_pre_reload: got led=%h expected 04", led);
        end
        do_load(LED_CHASE, 4'd0);
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (led !== ((j < 4) ? 8'h01 : 8'h02)) begin
                errors++;
                $display("FAIL chase_reload cyc=%0d: got led=%h expected %h",
                         j, led, (j < 4) ? 8'h01 : 8'h02);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_load(LED_BLINK, 4'd3);
        repeat (6) step();
        checks++;
        if (busy !== 1'b1 || led !== 8'h00) begin
            errors++;
            $display("FAIL first_burst_mid: got led=%h busy=%b expected led=00 busy=1", led, busy);
        end
        do_load(LED_BLINK, 4'd2);
        check_burst(2, "abort_burst2");
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        int on_cnt;
        int bad;
        do_load(LED_SOLID, 4'd0);
        duty = 2'd1;
        step();
        on_cnt = 0; bad = 0;
        for (int j = 0; j < 8; j++) begin
            if (led === 8'hFF) on_cnt++;
            else if (led !== 8'h00) bad++;
            step();
        end
        checks++;
        if (on_cnt != 2 || bad != 0) begin
            errors++;
            $display("FAIL pwm_duty1: got on=%0d other=%0d expected on=2 other=0", on_cnt, bad);
        end
        duty = 2'd3;
        step();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (led !== 8'hFF) begin
                errors++;
                $display("FAIL pwm_duty3 cyc=%0d: got led=%h expected FF", j, led);
            end
            step();
        end
        duty = 2'd0;
        step();
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (led !== 8'h00) begin
                errors++;
                $display("FAIL pwm_duty0 cyc=%0d: got led=%h expected 00", j, led);
            end
            step();
        end
        duty = 2'd3;
        step();
    endtask
`endif

    initial begin
`ifdef LED_PWM_EN
        duty = 2'd3;
`endif
        test_reset();
        test_solid_off();
        test_blink_endless();
        test_blink_burst();
        test_chase();
        test_reload();
        test_back_to_back();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern.md
Name: led_pattern

Overview:
- Parametrised LED pattern generator driving a bank of N_LED board LEDs from the system clock.
- Replaces the fixed 8-LED, externally-clocked blink gate.
- Internal tick divider sets the blink and chase rate.
- Supports off, solid, blink (endless or counted burst with completion pulse) and chase modes, selected at runtime by a load strobe.
- Sits between game-state control logic and the board LED pins.

Parameters:
- N_LED, 8, number of LEDs driven (>=2).
- BLINK_DIV, 25000000, clk cycles per tick (>=2). One tick = one blink half-period = one chase step.
- CNT_W, 4, width of burst count input.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- mode  in  2  requested mode: 0 OFF, 1 SOLID, 2 BLINK, 3 CHASE.
- load  in  1  one-cycle strobe; captures mode and cnt.
- cnt  in  CNT_W  burst length in on-phases for BLINK; 0 = endless. Ignored in other modes.
- led  out  N_LED  LED drive, registered, 1 = lit.
- busy  out  1  high while a counted burst is in progress.
- done  out  1  one-cycle pulse when a counted burst finishes.

Behaviour:
- Reset (rst=1 at an edge): mode_q=OFF, led=0, busy=0, done=0, divider=0, phase=on, chase=one-hot bit0, burst count=0. Reset wins over load in the same cycle.
- Divider: counts 0..BLINK_DIV-1. tick=1 in the cycle it equals BLINK_DIV-1, then wraps to 0. Cleared on every accepted load.
- Load latency: load sampled at edge k → new mode state and led pattern valid immediately after edge k. No combinational path from inputs to led. A load while busy aborts the burst: busy follows the new request, no done pulse.
- OFF: led=0. Divider keeps running; its ticks are ignored.
- SOLID: led all ones.
- BLINK:
  - Load sets phase=on, so led is all ones after the load edge.
  - Each tick toggles phase: led = all ones when on, all zeros when off.
  - Endless (cnt=0): toggles forever; busy=0.
  - Counted (cnt=C>0): load sets remaining=C and busy=1.
  - At each tick ending an on-phase, remaining decrements.
  - If remaining was 1 at that tick, mode_q goes to OFF at that edge: led=0, busy=0, done=1 for exactly one cycle.
  - Total lit phases = C. Total duration from load to done edge = (2C-1)*BLINK_DIV cycles.
- CHASE:
  - Load sets led = one-hot bit0.
  - Each tick rotates left by one; bit N_LED-1 wraps to bit0.
  - Exactly one LED is lit at all times.
- Same-mode reload: restarts the pattern (phase, chase position, divider, count) identically to a fresh load.
- done: never asserted except on counted-burst completion. Deasserts on the following edge.

Optional Feature:
- Macro LED_PWM_EN.
- Defined:
  - Adds parameter PWM_W (default 4) and input duty[PWM_W-1:0].
  - Adds a free-running PWM_W-bit pwm counter, reset to 0.
  - Every lit LED in every mode is ANDed with gate = (duty == all ones) || (pwm_cnt < duty).
  - duty=0 → led held 0 while logically lit. Unlit LEDs stay 0.
  - The gate is applied in the led output register, so latency is unchanged.
- Undefined: no duty port, no pwm counter; lit LEDs are full-on.
- Mode, busy and done behaviour are identical either way.

Decomposition:
- Package led_pkg: mode constants (LED_OFF=2'd0, LED_SOLID=2'd1, LED_BLINK=2'd2, LED_CHASE=2'd3) and the mode typedef; shared with control logic.
- One sub-module, led_tick_div, parameter BLINK_DIV:
  - Ports clk, rst, clr, tick.
  - Internal counter width $clog2(BLINK_DIV).
- led_pattern holds mode, phase, chase, burst and output registers.

Test Plan (N_LED=8, BLINK_DIV=4, CNT_W=4):
- Reset then idle 20 cycles → led=8'h00, busy=0, done=0 throughout. Assert rst mid-BLINK → led=8'h00 after that edge.
- load mode=SOLID → led=8'hFF after the load edge. Then load mode=OFF → led=8'h00 next edge.
- load BLINK cnt=0 → led=FF for 4 cycles, 00 for 4 cycles, repeating for 40 cycles; busy stays 0.
- load BLINK cnt=3 → three FF phases; at load+20 cycles led=00, busy 1→0, single done pulse; no further toggles.
- load CHASE → led 01,02,04,…,80,01, each held 4 cycles; wrap from 80 to 01 verified.
- With LED_PWM_EN, PWM_W=2:
  - SOLID with duty=1 → led=FF in 1 of every 4 cycles.
  - duty=3 → constant FF.
  - duty=0 → constant 00.
  - Load BLINK cnt=2 mid-burst of cnt=3 → no done from the first burst; done pulses once at the end of the second burst.
